decoder_nto2n_seq: RTL

//  Parametrised, registered N-to-2^N one-hot decoder with enable. Generalises the 2-to-4

---
 rtl/decoder_pkg.sv | 17 +
 rtl/dec_onehot.sv | 14 +
 rtl/decoder_nto2n_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared mode and state types for the sequenced N-to-2^N decoder
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_SCAN   = 2'd1,
        MODE_PULSE  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_PULSE = 2'd2
    } state_e;

endpackage

// File: rtl/dec_onehot.sv
// rtl/dec_onehot.sv - combinational SEL_W to 2^SEL_W one-hot decode
module dec_onehot #(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]      sel,
    output logic [(1<<SEL_W)-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// rtl/decoder_nto2n_seq.sv - registered one-hot decoder with direct, scan and pulse modes
// Define DECODER_ACT_LOW_EN for an active-low out bus (idle = all ones).
module decoder_nto2n_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W     = 2,
    parameter int STEP_DIV  = 4,
    parameter int PULSE_LEN = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      in,
    input  logic                  start,
    output logic [(1<<SEL_W)-1:0] out,
    output logic                  busy,
    output logic                  done
);

    localparam int OUT_W   = 1 << SEL_W;
    localparam int STEP_W  = $clog2(STEP_DIV + 1);
    localparam int PCNT_W  = $clog2(PULSE_LEN + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_LEN);

    state_e              state, state_nxt;
    logic [SEL_W-1:0]    idx, idx_nxt;
    logic [STEP_W-1:0]   step, step_nxt;
    logic [PCNT_W-1:0]   pcnt, pcnt_nxt;
    logic                on_nxt;
    logic                done_nxt;
    logic                done_q;
    logic [OUT_W-1:0]    onehot;
    logic [OUT_W-1:0]    out_q;

    // idx_nxt is always the index the output register will show next cycle,
    // so a single decoder serves every mode.
    dec_onehot #(.SEL_W(SEL_W)) u_dec (
        .sel    (idx_nxt),
        .onehot (onehot)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        step_nxt  = step;
        pcnt_nxt  = pcnt;
        on_nxt    = 1'b0;
        done_nxt  = 1'b0;
        if (!en) begin
            state_nxt = ST_IDLE;
            step_nxt  = '0;
            pcnt_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    case (mode_e'(mode))
                        MODE_SCAN: begin
                            if (start) begin
                                state_nxt = ST_SCAN;
                                idx_nxt   = in;
                                step_nxt  = '0;
                                on_nxt    = 1'b1;
                            end
                        end
                        MODE_PULSE: begin
                            if (start) begin
                                state_nxt = ST_PULSE;
                                idx_nxt   = in;
                                pcnt_nxt  = PCNT_W'(1);
                                on_nxt    = 1'b1;
                            end
                        end
                        default: begin
                            idx_nxt = in;
                            on_nxt  = 1'b1;
                        end
                    endcase
                end
                ST_SCAN: begin
                    if (start) begin
                        state_nxt = ST_IDLE;
                        step_nxt  = '0;
                    end else begin
                        on_nxt = 1'b1;
                        if (step == STEP_LAST) begin
                            step_nxt = '0;
                            idx_nxt  = idx + SEL_W'(1);
                        end else begin
                            step_nxt = step + STEP_W'(1);
                        end
                    end
                end
                ST_PULSE: begin
                    // pcnt counts asserted cycles, starting at 1 on the entry cycle
                    if (pcnt == PCNT_LAST) begin
                        state_nxt = ST_IDLE;
                        pcnt_nxt  = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        pcnt_nxt = pcnt + PCNT_W'(1);
                        on_nxt   = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            step   <= '0;
            pcnt   <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            step   <= step_nxt;
            pcnt   <= pcnt_nxt;
            out_q  <= on_nxt ? onehot : '0;
            done_q <= done_nxt;
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = done_q;

`ifdef DECODER_ACT_LOW_EN
    assign out = ~out_q;
`else
    assign out = out_q;
`endif

endmodule
